// File: rtl/movwide_encoder_if.sv
// Request/instruction stream bundle for movwide_encoder: 64-bit constant + Xd in,
// one 32-bit MOVZ/MOVK word per valid/ready beat out.
interface movwide_encoder_if;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_value;
    logic [4:0]  in_rd;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic        out_last;

    modport master (
        output in_valid, in_value, in_rd, out_ready,
        input  in_ready, out_valid, out_instr, out_last
    );

    modport slave (
        input  in_valid, in_value, in_rd, out_ready,
        output in_ready, out_valid, out_instr, out_last
    );
endinterface

// File: rtl/movwide_encoder.sv
// Emits MOVZ + MOVKs rebuilding a 64-bit constant; first word registered one cycle after accept,
// one word per handshake; out_instr/out_last hold while stalled, no new request until out_last accepted.
module movwide_encoder #(
    parameter bit SKIP_ZERO = 1'b1
) (
    input  logic              CLK,
    input  logic              resetl,
    movwide_encoder_if.slave  bus
);
    typedef enum logic {IDLE, EMIT} state_t;

    state_t      state, state_nxt;
    logic [63:0] value_q, value_nxt;
    logic [4:0]  rd_q, rd_nxt;
    logic [3:0]  pend_q, pend_nxt;
    logic [31:0] instr_q, instr_nxt;
    logic        last_q, last_nxt;
    logic [3:0]  nz_mask;
    logic [3:0]  start_mask;
    logic [1:0]  first_hw;
    logic [1:0]  next_hw;

    function automatic logic [1:0] low_idx(input logic [3:0] m);
        logic [1:0] idx;
        if (m[0])      idx = 2'd0;
        else if (m[1]) idx = 2'd1;
        else if (m[2]) idx = 2'd2;
        else           idx = 2'd3;
        return idx;
    endfunction

    // Opcode bits [31:23]: 0x1A5 is MOVZ (0xD28...), 0x1E5 is MOVK (0xF28...).
    function automatic logic [31:0] enc(input logic movk, input logic [1:0] hw,
                                        input logic [63:0] v, input logic [4:0] rd);
        logic [15:0] imm;
        imm = v[{hw, 4'b0000} +: 16];
        return {(movk ? 9'h1E5 : 9'h1A5), hw, imm, rd};
    endfunction

    assign nz_mask[0] = |bus.in_value[15:0];
    assign nz_mask[1] = |bus.in_value[31:16];
    assign nz_mask[2] = |bus.in_value[47:32];
    assign nz_mask[3] = |bus.in_value[63:48];

    // A zero constant still needs one MOVZ, placed at hw0.
    assign start_mask = SKIP_ZERO ? ((nz_mask == 4'b0000) ? 4'b0001 : nz_mask) : 4'b1111;
    assign first_hw   = low_idx(start_mask);
    assign next_hw    = low_idx(pend_q);

    always_comb begin
        state_nxt = state;
        value_nxt = value_q;
        rd_nxt    = rd_q;
        pend_nxt  = pend_q;
        instr_nxt = instr_q;
        last_nxt  = last_q;
        case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    state_nxt = EMIT;
                    value_nxt = bus.in_value;
                    rd_nxt    = bus.in_rd;
                    pend_nxt  = start_mask & ~(4'b0001 << first_hw);
                    instr_nxt = enc(1'b0, first_hw, bus.in_value, bus.in_rd);
                    last_nxt  = (pend_nxt == 4'b0000);
                end
            end
            EMIT: begin
                if (bus.out_ready) begin
                    if (last_q) begin
                        state_nxt = IDLE;
                        instr_nxt = 32'd0;
                        last_nxt  = 1'b0;
                    end else begin
                        pend_nxt  = pend_q & ~(4'b0001 << next_hw);
                        instr_nxt = enc(1'b1, next_hw, value_q, rd_q);
                        last_nxt  = (pend_nxt == 4'b0000);
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge resetl) begin
        if (!resetl) begin
            state   <= IDLE;
            value_q <= 64'd0;
            rd_q    <= 5'd0;
            pend_q  <= 4'd0;
            instr_q <= 32'd0;
            last_q  <= 1'b0;
        end else begin
            state   <= state_nxt;
            value_q <= value_nxt;
            rd_q    <= rd_nxt;
            pend_q  <= pend_nxt;
            instr_q <= instr_nxt;
            last_q  <= last_nxt;
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == EMIT);
    assign bus.out_instr = instr_q;
    assign bus.out_last  = last_q;
endmodule

// File: tb/tb_movwide_encoder.sv
// Scoreboard bench for movwide_encoder: SKIP_ZERO=1 and SKIP_ZERO=0 instances share one
// expected-beat queue; only one instance is driven at a time.
module tb_movwide_encoder;
    logic        CLK = 1'b0;
    logic        resetl;
    logic        in_vld;
    logic        sel;
    logic [63:0] in_val;
    logic [4:0]  in_rdv;
    logic        out_rdy = 1'b1;
    logic        toggle_rdy = 1'b0;
    int          rdy_cnt = 0;
    int          checks = 0;
    int          errors = 0;
    int          beats = 0;
    logic [32:0] exp_q[$];

    movwide_encoder_if bus_a();
    movwide_encoder_if bus_b();

    assign bus_a.in_valid  = in_vld & !sel;
    assign bus_b.in_valid  = in_vld & sel;
    assign bus_a.in_value  = in_val;
    assign bus_b.in_value  = in_val;
    assign bus_a.in_rd     = in_rdv;
    assign bus_b.in_rd     = in_rdv;
    assign bus_a.out_ready = out_rdy;
    assign bus_b.out_ready = out_rdy;

    movwide_encoder #(.SKIP_ZERO(1'b1)) dut_a (.CLK(CLK), .resetl(resetl), .bus(bus_a.slave));
    movwide_encoder #(.SKIP_ZERO(1'b0)) dut_b (.CLK(CLK), .resetl(resetl), .bus(bus_b.slave));

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // out_ready pattern 1,0,0,1 repeating when toggling, else held high
    always @(posedge CLK) begin
        #1;
        if (toggle_rdy) begin
            out_rdy = ((rdy_cnt % 4) == 0) || ((rdy_cnt % 4) == 3);
            rdy_cnt++;
        end else begin
            out_rdy = 1'b1;
        end
    end

    logic        m_vld, m_last;
    logic [31:0] m_instr;
    assign m_vld   = bus_a.out_valid | bus_b.out_valid;
    assign m_instr = bus_a.out_valid ? bus_a.out_instr : bus_b.out_instr;
    assign m_last  = bus_a.out_valid ? bus_a.out_last  : bus_b.out_last;

    logic        stalled = 1'b0;
    logic [31:0] held_instr;
    logic        held_last;
    logic [32:0] ent;

    always @(negedge CLK) begin
        if (!resetl) begin
            stalled = 1'b0;
        end else begin
            if (stalled && m_vld) begin
                chk("stall_instr", m_instr, held_instr);
                chk("stall_last", m_last, held_last);
            end
            if (m_vld && out_rdy) begin
                chk("beat_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    ent = exp_q.pop_front();
                    chk("beat_instr", m_instr, ent[31:0]);
                    chk("beat_last", m_last, ent[32]);
                end
                beats++;
                stalled = 1'b0;
            end else if (m_vld) begin
                stalled    = 1'b1;
                held_instr = m_instr;
                held_last  = m_last;
            end else begin
                stalled = 1'b0;
            end
        end
    end

    task automatic push_exp(input logic [31:0] w, input logic last);
        exp_q.push_back({last, w});
    endtask

    task automatic push_model(input logic [63:0] v, input logic [4:0] rd, input bit skip);
        logic [32:0] lst[$];
        logic [32:0] tmp;
        logic [15:0] imm;
        for (int hw = 0; hw < 4; hw++) begin
            imm = v[16*hw +: 16];
            if (!skip || imm != 16'd0)
                lst.push_back({1'b0, ((lst.size() == 0) ? 32'hD2800000 : 32'hF2800000)
                               | (32'(hw) << 21) | (32'(imm) << 5) | 32'(rd)});
        end
        if (lst.size() == 0) lst.push_back({1'b0, 32'hD2800000 | 32'(rd)});
        tmp = lst.pop_back();
        tmp[32] = 1'b1;
        lst.push_back(tmp);
        foreach (lst[i]) exp_q.push_back(lst[i]);
    endtask

    // Called at posedge+1 with the target idle; leaves in_valid high with scrambled data
    // so acceptance while busy would show up as extra beats.
    task automatic send(input bit use_b, input logic [63:0] v, input logic [4:0] rd);
        sel    = use_b;
        in_val = v;
        in_rdv = rd;
        in_vld = 1'b1;
        @(posedge CLK);
        #1;
        chk("first_valid", use_b ? bus_b.out_valid : bus_a.out_valid, 1);
        chk("busy_ready", use_b ? bus_b.in_ready : bus_a.in_ready, 0);
        in_val = ~v;
        in_rdv = ~rd;
    endtask

    task automatic wait_done(input bit use_b);
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge CLK);
            n++;
        end
        chk("drain_timeout", exp_q.size(), 0);
        #1;
        chk("ready_back", use_b ? bus_b.in_ready : bus_a.in_ready, 1);
        chk("valid_off", use_b ? bus_b.out_valid : bus_a.out_valid, 0);
        in_vld = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int b0;
        int n;
        logic [63:0] v;
        logic [3:0]  zm;
        resetl = 1'b0;
        in_vld = 1'b0;
        sel    = 1'b0;
        in_val = 64'd0;
        in_rdv = 5'd0;
        #12;
        chk("rst_valid_a", bus_a.out_valid, 0);
        chk("rst_ready_a", bus_a.in_ready, 1);
        chk("rst_instr_a", bus_a.out_instr, 0);
        chk("rst_last_a", bus_a.out_last, 0);
        chk("rst_valid_b", bus_b.out_valid, 0);
        chk("rst_ready_b", bus_b.in_ready, 1);
        @(posedge CLK); #1;
        resetl = 1'b1;
        @(posedge CLK); #1;

        push_exp(32'hD2800003, 1'b1);
        send(0, 64'h0, 5'd3);
        wait_done(0);

        push_exp(32'hD2A00020, 1'b1);
        send(0, 64'h0000_0000_0001_0000, 5'd0);
        wait_done(0);

        push_exp(32'hD28ACF01, 1'b0);
        push_exp(32'hF2E24681, 1'b1);
        send(0, 64'h1234_0000_0000_5678, 5'd1);
        wait_done(0);

        rdy_cnt = 0;
        toggle_rdy = 1'b1;
        push_exp(32'hD29FFFFF, 1'b0);
        push_exp(32'hF2BFFFFF, 1'b0);
        push_exp(32'hF2DFFFFF, 1'b0);
        push_exp(32'hF2FFFFFF, 1'b1);
        send(0, 64'hFFFF_FFFF_FFFF_FFFF, 5'd31);
        wait_done(0);
        toggle_rdy = 1'b0;

        // Reset in the middle of the all-ones sequence
        @(posedge CLK); #1;
        rdy_cnt = 0;
        toggle_rdy = 1'b1;
        push_exp(32'hD29FFFFF, 1'b0);
        push_exp(32'hF2BFFFFF, 1'b0);
        push_exp(32'hF2DFFFFF, 1'b0);
        push_exp(32'hF2FFFFFF, 1'b1);
        b0 = beats;
        send(0, 64'hFFFF_FFFF_FFFF_FFFF, 5'd31);
        n = 0;
        while (beats < b0 + 2 && n < 100) begin
            @(posedge CLK);
            n++;
        end
        chk("two_beats_seen", beats - b0, 2);
        #2;
        resetl = 1'b0;
        #1;
        chk("midrst_valid", bus_a.out_valid, 0);
        chk("midrst_ready", bus_a.in_ready, 1);
        chk("midrst_instr", bus_a.out_instr, 0);
        chk("midrst_last", bus_a.out_last, 0);
        exp_q.delete();
        in_vld = 1'b0;
        toggle_rdy = 1'b0;
        @(posedge CLK); #1;
        resetl = 1'b1;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        chk("postrst_quiet", bus_a.out_valid, 0);
        push_exp(32'hD28000A2, 1'b1);
        send(0, 64'h5, 5'd2);
        wait_done(0);

        push_exp(32'hD2800000, 1'b0);
        push_exp(32'hF2A00000, 1'b0);
        push_exp(32'hF2C00000, 1'b0);
        push_exp(32'hF2E00000, 1'b1);
        send(1, 64'h0, 5'd0);
        wait_done(1);

        for (int i = 0; i < 8; i++) begin
            v  = {$urandom, $urandom};
            zm = 4'($urandom_range(0, 15));
            for (int h = 0; h < 4; h++) if (zm[h]) v[16*h +: 16] = 16'd0;
            toggle_rdy = (i % 2) == 1;
            rdy_cnt = 0;
            push_model(v, 5'(i * 5), (i % 3) != 2);
            send((i % 3) == 2, v, 5'(i * 5));
            wait_done((i % 3) == 2);
            toggle_rdy = 1'b0;
            @(posedge CLK); #1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
